split_assign_gen: RTL and testbench

- Candidate-assignment generator that drives the packed variable bus of a `split_*` constraint checker and collects its single-bit `x` verdict.
- It is the producer side of the checker interface. The checker consumes variable buses and answers `x`; this block generates pseudo-random assignments, presents them, samples `x`, and streams accepted assignments downstream.
- It sits between the solver controller (start/seed/limits) and one `split_*` instance.

---
 rtl/split_assign_gen.sv | 216 +++++++++++++++++++++
 tb/tb_split_assign_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_assign_gen.sv
// split_assign_gen: pseudo-random candidate generator for a split_* checker.
// Fills cand from a 32-bit Galois LFSR one word per cycle, presents it,
// samples chk_x CHECK_LAT cycles later and streams accepted candidates.
// Optional macro SPLIT_GEN_FIXMASK_EN adds fix_mask/fix_val pinning inputs.
module split_assign_gen #(
    parameter int VEC_W     = 64,
    parameter int CHECK_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_sol,
    input  logic [CNT_W-1:0] max_tries,
`ifdef SPLIT_GEN_FIXMASK_EN
    input  logic [VEC_W-1:0] fix_mask,
    input  logic [VEC_W-1:0] fix_val,
`endif
    output logic [VEC_W-1:0] cand,
    output logic             cand_valid,
    input  logic             chk_x,
    output logic [VEC_W-1:0] sol,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] tried_cnt,
    output logic [CNT_W-1:0] found_cnt
);

    localparam int          WORDS     = (VEC_W + 31) / 32;
    localparam int          IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [2:0]  LAT_LAST  = (CHECK_LAT > 0) ? 3'(CHECK_LAT - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PRESENT, S_WAIT, S_EMIT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_nx;
    logic [IDX_W-1:0] word_q, word_d;
    logic [2:0]       wait_q, wait_d;
    logic [VEC_W-1:0] cand_q, cand_d, sol_q, sol_d;
    logic [CNT_W-1:0] tried_q, tried_d, found_q, found_d;
    logic [CNT_W-1:0] num_q, num_d, max_q, max_d;
    logic             timeout_q, timeout_d, done_q, done_d;
    logic             sample, decide;
`ifdef SPLIT_GEN_FIXMASK_EN
    logic [VEC_W-1:0] fmask_q, fmask_d, fval_q, fval_d;
`endif

    // One Galois step: shift right, fold the mask in when the LSB falls out.
    always_comb begin
        lfsr_nx = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    end

    // Next-state logic; sample and decide merge the paths shared by
    // PRESENT/WAIT (verdict) and the verdict/EMIT (check step).
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        word_d    = word_q;
        wait_d    = wait_q;
        cand_d    = cand_q;
        sol_d     = sol_q;
        tried_d   = tried_q;
        found_d   = found_q;
        num_d     = num_q;
        max_d     = max_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        sample    = 1'b0;
        decide    = 1'b0;
`ifdef SPLIT_GEN_FIXMASK_EN
        fmask_d   = fmask_q;
        fval_d    = fval_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d    = (seed == 32'h0) ? 32'h1 : seed;
                    num_d     = num_sol;
                    max_d     = max_tries;
                    tried_d   = '0;
                    found_d   = '0;
                    timeout_d = 1'b0;
                    word_d    = '0;
`ifdef SPLIT_GEN_FIXMASK_EN
                    fmask_d   = fix_mask;
                    fval_d    = fix_val;
`endif
                    if (num_sol == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                lfsr_d = lfsr_nx;
                for (int unsigned b = 0; b < VEC_W; b++) begin
                    if (word_q == IDX_W'(b / 32)) begin
`ifdef SPLIT_GEN_FIXMASK_EN
                        cand_d[b] = fmask_q[b] ? fval_q[b] : lfsr_nx[b % 32];
`else
                        cand_d[b] = lfsr_nx[b % 32];
`endif
                    end
                end
                if (word_q == IDX_W'(WORDS - 1)) begin
                    word_d  = '0;
                    state_d = S_PRESENT;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            S_PRESENT: begin
                if (CHECK_LAT == 0) begin
                    sample = 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == LAT_LAST) sample = 1'b1;
                else                    wait_d = wait_q + 1'b1;
            end
            S_EMIT: begin
                if (sol_ready) begin
                    found_d = found_q + 1'b1;
                    decide  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sample) begin
            tried_d = (tried_q == '1) ? tried_q : tried_q + 1'b1;
            if (chk_x) begin
                sol_d   = cand_q;
                state_d = S_EMIT;
            end else begin
                decide = 1'b1;
            end
        end

        // Success is tested first so that hitting both limits is not a timeout.
        if (decide) begin
            if (found_d == num_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else if (max_q != '0 && tried_d == max_q) begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                state_d = S_FILL;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 32'h1;
            word_q    <= '0;
            wait_q    <= '0;
            cand_q    <= '0;
            sol_q     <= '0;
            tried_q   <= '0;
            found_q   <= '0;
            num_q     <= '0;
            max_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPLIT_GEN_FIXMASK_EN
            fmask_q   <= '0;
            fval_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            word_q    <= word_d;
            wait_q    <= wait_d;
            cand_q    <= cand_d;
            sol_q     <= sol_d;
            tried_q   <= tried_d;
            found_q   <= found_d;
            num_q     <= num_d;
            max_q     <= max_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
`ifdef SPLIT_GEN_FIXMASK_EN
            fmask_q   <= fmask_d;
            fval_q    <= fval_d;
`endif
        end
    end

    assign cand       = cand_q;
    assign cand_valid = (state_q == S_PRESENT);
    assign sol        = sol_q;
    assign sol_valid  = (state_q == S_EMIT);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign tried_cnt  = tried_q;
    assign found_cnt  = found_q;

endmodule

// File: tb/tb_split_assign_gen.sv
// Bench for split_assign_gen: two instances (64-bit/latency 3 and
// 40-bit/latency 0) driven by shared stimulus, each checked every cycle
// against an event-timed reference model.
module tb_split_assign_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = 32'h1;
    logic [15:0] num_sol = 16'd1;
    logic [15:0] max_tries = 16'd0;
    logic        sol_ready = 1'b1;
    int          mode = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [63:0] cand_w [2];
    logic [63:0] sol_w [2];
    logic        cv_w [2];
    logic        sv_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        to_w [2];
    logic [15:0] tried_w [2];
    logic [15:0] found_w [2];
    int          cvc_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h want %h (cycle %0d)", g, nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic accept(input int md, input logic [63:0] c);
        if (md == 1) return 1'b1;
        if (md == 2) return c[9:8] == 2'b11;
        return 1'b0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int VW  = (g == 0) ? 64 : 40;
        localparam int LAT = (g == 0) ? 3 : 0;
        localparam int WW  = (VW + 31) / 32;
        localparam logic [63:0] VMASK = {64{1'b1}} >> (64 - VW);

        logic [VW-1:0] cand, sol;
        logic          cv, sv, busy, done, to, chk_x, acc;
        logic [15:0]   tried, found;

        split_assign_gen #(.VEC_W(VW), .CHECK_LAT(LAT), .CNT_W(16)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
            .num_sol(num_sol), .max_tries(max_tries),
`ifdef SPLIT_GEN_FIXMASK_EN
            .fix_mask(VW'(64'hFF)), .fix_val(VW'(64'hA5)),
`endif
            .cand(cand), .cand_valid(cv), .chk_x(chk_x), .sol(sol),
            .sol_valid(sv), .sol_ready(sol_ready), .busy(busy), .done(done),
            .timeout(to), .tried_cnt(tried), .found_cnt(found)
        );

        assign cand_w[g]  = 64'(cand);
        assign sol_w[g]   = 64'(sol);
        assign cv_w[g]    = cv;
        assign sv_w[g]    = sv;
        assign busy_w[g]  = busy;
        assign done_w[g]  = done;
        assign to_w[g]    = to;
        assign tried_w[g] = tried;
        assign found_w[g] = found;
        assign acc        = accept(mode, 64'(cand));

        // Checker stub: verdict is 1 only in the exact cycle LAT after cand_valid.
        if (LAT == 0) begin : g_comb
            assign chk_x = cv & acc;
        end else begin : g_pipe
            logic [7:0] sr;
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[6:0], cv & acc};
            end
            assign chk_x = sr[LAT-1];
        end

        int          m_cand_cyc = -1, m_sample = -1, m_sol_start = -1, m_done = -1;
        bit          m_busy = 0, m_pend = 0, m_v = 0, m_to = 0;
        logic [31:0] m_lfsr = 32'h1;
        logic [63:0] m_cand = '0, m_sol = '0, tmp;
        int          m_tried = 0, m_found = 0, m_num = 0, m_max = 0;

        initial cvc_w[g] = 0;

        // Reference model: candidates, sample, emit and done are predicted as
        // cycle numbers; DUT outputs are compared every negedge.
        always @(negedge clk) begin
            bit busy_now, dec;
            if (!rst_n) begin
                chk(g, "rst cand_valid", 64'(cv), 64'd0);
                chk(g, "rst sol_valid", 64'(sv), 64'd0);
                chk(g, "rst busy", 64'(busy), 64'd0);
                chk(g, "rst done", 64'(done), 64'd0);
                chk(g, "rst timeout", 64'(to), 64'd0);
                chk(g, "rst counters", {32'd0, tried, found}, 64'd0);
                chk(g, "rst cand", 64'(cand), 64'd0);
                chk(g, "rst sol", 64'(sol), 64'd0);
                m_cand_cyc = -1; m_sample = -1; m_sol_start = -1; m_done = -1;
                m_busy = 0; m_pend = 0; m_to = 0; m_tried = 0; m_found = 0;
            end else begin
                chk(g, "cand_valid", 64'(cv), 64'(cyc == m_cand_cyc));
                chk(g, "sol_valid", 64'(sv), 64'(m_pend && cyc >= m_sol_start));
                chk(g, "done", 64'(done), 64'(cyc == m_done));
                chk(g, "busy", 64'(busy), 64'(m_busy));
                chk(g, "timeout", 64'(to), 64'(m_to));
                chk(g, "tried_cnt", 64'(tried), 64'(m_tried));
                chk(g, "found_cnt", 64'(found), 64'(m_found));
                busy_now = m_busy;
                dec = 0;
                if (cyc == m_cand_cyc) begin
                    tmp = '0;
                    for (int k = 0; k < WW; k++) begin
                        m_lfsr = adv(m_lfsr);
                        tmp[k*32 +: 32] = m_lfsr;
                    end
                    tmp = tmp & VMASK;
`ifdef SPLIT_GEN_FIXMASK_EN
                    tmp = (tmp & ~64'hFF) | 64'hA5;
`endif
                    m_cand = tmp;
                    chk(g, "cand", 64'(cand), m_cand);
                    m_v = accept(mode, m_cand);
                    m_sample = cyc + LAT;
                    cvc_w[g] = cvc_w[g] + 1;
                end
                if (cyc == m_sample) begin
                    if (m_tried < 65535) m_tried++;
                    if (m_v) begin
                        m_pend = 1; m_sol = m_cand; m_sol_start = cyc + 1;
                    end else begin
                        dec = 1;
                    end
                end
                if (m_pend && cyc >= m_sol_start) begin
                    chk(g, "sol", 64'(sol), m_sol);
                    if (sol_ready) begin
                        m_found++; m_pend = 0; dec = 1;
                    end
                end
                if (dec) begin
                    if (m_found == m_num) begin
                        m_done = cyc + 1; m_busy = 0;
                    end else if (m_max != 0 && m_tried == m_max) begin
                        m_done = cyc + 1; m_busy = 0; m_to = 1;
                    end else begin
                        m_cand_cyc = cyc + WW + 1;
                    end
                end
                if (start && !busy_now) begin
                    m_lfsr = (seed == 0) ? 32'h1 : seed;
                    m_num = int'(num_sol); m_max = int'(max_tries);
                    m_tried = 0; m_found = 0; m_to = 0;
                    if (num_sol == 0) begin
                        m_done = cyc + 1; m_busy = 0;
                    end else begin
                        m_cand_cyc = cyc + WW + 1; m_busy = 1;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_wait(input int lim, input bit rnd_ready);
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < lim) begin
            @(posedge clk); #1;
            if (rnd_ready) sol_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= lim) begin
            n_tests++; n_fail++;
            $display("FAIL run_wait: still busy after %0d cycles, want idle", lim);
        end
        sol_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_sol(input int lim);
        int n = 0;
        while (!sv_w[0] && n < lim) begin
            @(posedge clk); #1; n++;
        end
        if (n >= lim) begin
            n_tests++; n_fail++;
            $display("FAIL wait_sol: no sol_valid after %0d cycles, want 1", lim);
        end
    endtask

    logic [63:0] lit_a, lit_b;
    int          cv_before;

    initial begin
`ifdef SPLIT_GEN_FIXMASK_EN
        lit_a = 64'hC030_0002_8020_00A5;
        lit_b = 64'h02_8020_00A5;
`else
        lit_a = 64'hC030_0002_8020_0003;
        lit_b = 64'h02_8020_0003;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Word fill from seed 1, always-accepting stub.
        mode = 1; seed = 32'h1; num_sol = 1; max_tries = 0;
        pulse_start();
        run_wait(200, 0);
        chk(0, "fill sol literal", sol_w[0], lit_a);
        chk(1, "fill sol literal", sol_w[1], lit_b);
        chk(0, "fill tried", 64'(tried_w[0]), 64'd1);
        chk(0, "fill found", 64'(found_w[0]), 64'd1);

        // Timeout after 5 rejected candidates.
        mode = 0; max_tries = 5; num_sol = 3; seed = 32'h1234_5678;
        cv_before = cvc_w[0];
        pulse_start();
        run_wait(400, 0);
        chk(0, "timeout pulses", 64'(cvc_w[0] - cv_before), 64'd5);
        chk(0, "timeout flag", 64'(to_w[0]), 64'd1);
        chk(1, "timeout flag", 64'(to_w[1]), 64'd1);
        chk(0, "timeout tried", 64'(tried_w[0]), 64'd5);
        chk(0, "timeout found", 64'(found_w[0]), 64'd0);

        // Backpressure: ready low for 10 cycles while a solution is pending.
        mode = 1; num_sol = 2; max_tries = 0; seed = 32'hDEAD_BEEF; sol_ready = 1'b0;
        pulse_start();
        wait_sol(100);
        repeat (10) @(posedge clk);
        #1 sol_ready = 1'b1;
        run_wait(400, 0);
        chk(0, "bp found", 64'(found_w[0]), 64'd2);
        chk(0, "bp timeout", 64'(to_w[0]), 64'd0);

        // Latency: every candidate accepted only if sampled at the exact cycle.
        mode = 1; num_sol = 4; seed = $urandom;
        pulse_start();
        run_wait(400, 0);
        chk(0, "lat found", 64'(found_w[0]), 64'd4);
        chk(0, "lat tried", 64'(tried_w[0]), 64'd4);
        chk(1, "lat found", 64'(found_w[1]), 64'd4);
        chk(1, "lat tried", 64'(tried_w[1]), 64'd4);

        // Both limits on the same candidate: success wins.
        mode = 1; num_sol = 1; max_tries = 1;
        pulse_start();
        run_wait(200, 0);
        chk(0, "both limits timeout", 64'(to_w[0]), 64'd0);

        // num_sol = 0 finishes the cycle after start.
        num_sol = 0; max_tries = 0;
        cv_before = cvc_w[0];
        pulse_start();
        chk(0, "num0 done", 64'(done_w[0]), 64'd1);
        run_wait(20, 0);
        chk(0, "num0 pulses", 64'(cvc_w[0] - cv_before), 64'd0);

        // Start while busy is ignored (second start would finish at once).
        mode = 0; num_sol = 1; max_tries = 6; seed = 32'h0BAD_F00D;
        pulse_start();
        repeat (3) @(posedge clk);
        #1 num_sol = 0; seed = 32'h5;
        pulse_start();
        run_wait(400, 0);
        chk(0, "busy start tried", 64'(tried_w[0]), 64'd6);

        // Randomised runs; first uses seed 0.
        for (int r = 0; r < 12; r++) begin
            mode = 2;
            seed = (r == 0) ? 32'h0 : $urandom;
            num_sol = 16'($urandom_range(1, 4));
            max_tries = 16'($urandom_range(0, 10));
            pulse_start();
            run_wait(4000, 1);
        end

        // Reset asserted during EMIT.
        mode = 1; num_sol = 3; max_tries = 0; seed = 32'h77; sol_ready = 1'b0;
        pulse_start();
        wait_sol(100);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk(0, "rst in emit sol_valid", 64'(sv_w[0]), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        sol_ready = 1'b1; mode = 2; num_sol = 2; max_tries = 8; seed = $urandom;
        pulse_start();
        chk(0, "start after reset busy", 64'(busy_w[0]), 64'd1);
        run_wait(2000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
